// File: rtl/mem_load_ctrl_if.sv
// Stream-in / memory-write-out bundle for the frame loader; clk and rst_n stay outside.
// slave = loader side, master = stream source / memory / status consumer side.
interface mem_load_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [DW-1:0] byte_in;
  logic          byte_valid;
  logic          abort;
  logic          clear_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  modport slave (
    input  byte_in, byte_valid, abort, clear_err,
    output mem_we, mem_addr, mem_data, busy, done, err, err_code
  );

  modport master (
    output byte_in, byte_valid, abort, clear_err,
    input  mem_we, mem_addr, mem_data, busy, done, err, err_code
  );
endinterface

// File: rtl/mem_load_ctrl.sv
// Frame parser [addr, len, data x len] driving a memory write port; one cycle byte_valid -> mem_we.
// No backpressure: every byte_valid strobe is consumed at full rate; range/timeout/abort resync to IDLE.
module mem_load_ctrl #(
  parameter int DEPTH   = 164,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_load_ctrl_if.slave bus
);

  localparam int            TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_GET_LEN, S_DATA, S_SKIP} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_start_addr;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_remaining;
  logic [TW-1:0] r_tcnt;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic          w_we, w_done, w_err_set, w_start_ld, w_len_ld, w_dec, w_timeout;
  logic [1:0]    w_err_code;
  logic [AW:0]   w_end;

  // Sum is one bit wider than the address so a frame past the top can never wrap into range.
  assign w_end     = (AW + 1)'(r_start_addr) + (AW + 1)'(bus.byte_in);
  assign w_timeout = (r_state != S_IDLE) && !bus.byte_valid && (r_tcnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_done      = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = 2'b00;
    w_start_ld  = 1'b0;
    w_len_ld    = 1'b0;
    w_dec       = 1'b0;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      if (r_state != S_IDLE) begin
        w_err_set  = 1'b1;
        w_err_code = 2'b11;
      end
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err_set   = 1'b1;
      w_err_code  = 2'b10;
    end else if (bus.byte_valid) begin
      case (r_state)
        S_IDLE: begin
          w_start_ld  = 1'b1;
          w_state_nxt = S_GET_LEN;
        end
        S_GET_LEN: begin
          if (bus.byte_in == '0) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_end > DEPTH_X) begin
            w_len_ld    = 1'b1;
            w_err_set   = 1'b1;
            w_err_code  = 2'b01;
            w_state_nxt = S_SKIP;
          end else begin
            w_len_ld    = 1'b1;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_we  = 1'b1;
          w_dec = 1'b1;
          if (r_remaining == DW'(1)) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_SKIP: begin
          w_dec = 1'b1;
          if (r_remaining == DW'(1)) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_start_addr <= '0;
      r_wr_addr    <= '0;
      r_remaining  <= '0;
      r_tcnt       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= w_we;
      r_done   <= w_done;
      if (w_start_ld) r_start_addr <= AW'(bus.byte_in);
      if (w_len_ld) begin
        r_wr_addr   <= r_start_addr;
        r_remaining <= bus.byte_in;
      end else if (w_dec) begin
        r_remaining <= r_remaining - DW'(1);
      end
      if (w_we) begin
        r_mem_addr <= r_wr_addr;
        r_mem_data <= bus.byte_in;
        r_wr_addr  <= r_wr_addr + AW'(1);
      end
      if (bus.byte_valid || w_state_nxt == S_IDLE) r_tcnt <= '0;
      else                                         r_tcnt <= r_tcnt + TW'(1);
      // A new error in the same cycle as clear_err takes precedence.
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end else if (bus.clear_err) begin
        r_err      <= 1'b0;
        r_err_code <= 2'b00;
      end
    end
  end

  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed frames with a write/done scoreboard; a negedge monitor pops expectations on every mem_we or done.
module tb_mem_load_ctrl;

  localparam int TIMEOUT = 1000;

  logic clk;
  logic rst_n;

  mem_load_ctrl_if #(.AW(8), .DW(8)) bus ();

  mem_load_ctrl #(.DEPTH(164), .AW(8), .DW(8), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t ew(input logic [7:0] a, input logic [7:0] d, input logic dn);
    exp_t e;
    e.we = 1'b1; e.addr = a; e.data = d; e.done = dn;
    return e;
  endfunction

  // Scoreboard monitor: every write or done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.mem_we || bus.done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output we=%0b addr=%0h data=%0h done=%0b expected=none at %0t",
                 bus.mem_we, bus.mem_addr, bus.mem_data, bus.done, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_we", 32'(bus.mem_we), 32'(e.we));
        if (e.we) begin
          chk("sb_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("sb_data", 32'(bus.mem_data), 32'(e.data));
        end
        chk("sb_done", 32'(bus.done), 32'(e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.abort      = 1'b0;
    bus.clear_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_code", 32'(bus.err_code), 0);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back frame at address 0.
    exp_q.push_back(ew(8'h00, 8'hAA, 1'b0));
    exp_q.push_back(ew(8'h01, 8'hBB, 1'b0));
    exp_q.push_back(ew(8'h02, 8'hCC, 1'b1));
    put(8'h00); put(8'h03); put(8'hAA); put(8'hBB); put(8'hCC);
    idle(3);
    chk("t1_busy", 32'(bus.busy), 0);
    chk("t1_err", 32'(bus.err), 0);

    // Top boundary 162..163.
    exp_q.push_back(ew(8'hA2, 8'h11, 1'b0));
    exp_q.push_back(ew(8'hA3, 8'h22, 1'b1));
    put(8'hA2); put(8'h02); put(8'h11); put(8'h22);
    idle(3);
    chk("t2_err", 32'(bus.err), 0);

    // One past the top: skipped, range error, then recovery.
    put(8'hA3); put(8'h02); put(8'h55); put(8'h66);
    idle(2);
    chk("t3_err", 32'(bus.err), 1);
    chk("t3_code", 32'(bus.err_code), 32'h1);
    chk("t3_busy", 32'(bus.busy), 0);
    exp_q.push_back(ew(8'h05, 8'h77, 1'b1));
    put(8'h05); put(8'h01); put(8'h77);
    idle(3);
    chk("t3_code_sticky", 32'(bus.err_code), 32'h1);

    bus.clear_err = 1'b1;
    idle(1);
    bus.clear_err = 1'b0;
    chk("clr1_err", 32'(bus.err), 0);

    // Timeout mid-frame: still busy after TIMEOUT-1 silent cycles, idle after TIMEOUT.
    exp_q.push_back(ew(8'h10, 8'h01, 1'b0));
    put(8'h10); put(8'h04); put(8'h01);
    idle(TIMEOUT - 1);
    chk("t4_busy_before", 32'(bus.busy), 1);
    chk("t4_err_before", 32'(bus.err), 0);
    idle(1);
    chk("t4_busy_after", 32'(bus.busy), 0);
    chk("t4_err", 32'(bus.err), 1);
    chk("t4_code", 32'(bus.err_code), 32'h2);
    exp_q.push_back(ew(8'h20, 8'h99, 1'b1));
    put(8'h20); put(8'h01); put(8'h99);
    idle(3);

    // Abort coincident with the second data byte drops that byte.
    exp_q.push_back(ew(8'h00, 8'hD0, 1'b0));
    put(8'h00); put(8'h05); put(8'hD0);
    bus.abort = 1'b1;
    put(8'hD1);
    bus.abort = 1'b0;
    bus.byte_valid = 1'b0;
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_err", 32'(bus.err), 1);
    chk("t5_code", 32'(bus.err_code), 32'h3);
    idle(2);
    bus.clear_err = 1'b1;
    idle(1);
    bus.clear_err = 1'b0;
    chk("t5_clr_err", 32'(bus.err), 0);
    chk("t5_clr_code", 32'(bus.err_code), 0);

    // Abort while idle has no effect.
    bus.abort = 1'b1;
    idle(1);
    bus.abort = 1'b0;
    chk("idle_abort_err", 32'(bus.err), 0);

    // Zero-length frame: done without a write.
    exp_q.push_back('{we: 1'b0, addr: 8'h00, data: 8'h00, done: 1'b1});
    put(8'h30); put(8'h00);
    idle(3);
    chk("t6_busy", 32'(bus.busy), 0);

    // Reset mid-frame clears outputs at once; next byte is an address.
    exp_q.push_back(ew(8'h40, 8'hE1, 1'b0));
    put(8'h40); put(8'h03); put(8'hE1);
    idle(1);
    chk("t7_busy_pre", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", 32'(bus.busy), 0);
    chk("t7_rst_addr", 32'(bus.mem_addr), 0);
    chk("t7_rst_data", 32'(bus.mem_data), 0);
    chk("t7_rst_we", 32'(bus.mem_we), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(ew(8'h50, 8'hF1, 1'b1));
    put(8'h50); put(8'h01); put(8'hF1);
    idle(3);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_load_ctrl.md
Name: mem_load_ctrl

Overview:
- Frame-based write sequencer for the 164x8 parameter register file.
- Consumes a byte stream from the serial receiver (one-cycle byte_valid strobes).
- Parses frames of the form [start address, length, data x length] and drives the memory write port with auto-incrementing addresses.
- Range-checks each frame, resynchronises on errors or timeouts, and reports completion and error status to the top level.

Parameters:
DEPTH, 164, number of memory words; the highest legal address is DEPTH-1
AW, 8, memory address width
DW, 8, data and stream byte width
TIMEOUT, 1000, idle cycles allowed between bytes inside a frame before the frame is aborted

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
byte_in  in  DW  received stream byte; sampled only when byte_valid=1
byte_valid  in  1  one-cycle strobe qualifying byte_in
abort  in  1  software abort; forces the FSM to IDLE
clear_err  in  1  clears err and err_code
mem_we  out  1  memory write enable, one cycle per data byte
mem_addr  out  AW  memory write address
mem_data  out  DW  memory write data
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a frame completes
err  out  1  sticky error flag
err_code  out  2  last error: 01 = range, 10 = timeout, 11 = abort

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0; internal addr, remaining-count and timeout counters all 0.
- FSM states: IDLE, GET_LEN, DATA, SKIP.
- IDLE:
  - On byte_valid, latch byte_in as start_addr and go to GET_LEN.
  - busy=0.
  - No timeout counting.
- GET_LEN, on byte_valid, with len=byte_in:
  - len=0: done pulses next cycle; go to IDLE; no writes.
  - start_addr+len > DEPTH (9-bit compare, no wrap): go to SKIP with remaining=len; set err, err_code=01.
  - Otherwise: go to DATA with wr_addr=start_addr and remaining=len.
- DATA, on each byte_valid:
  - Next cycle: mem_we=1, mem_addr=wr_addr, mem_data=byte_in.
  - Then wr_addr+=1 and remaining-=1.
  - On the byte that takes remaining to 0: go to IDLE; done=1 in the same cycle as that final mem_we.
  - mem_we is 0 on all other cycles; mem_addr and mem_data hold their last values.
- SKIP:
  - Consume remaining bytes with no mem_we.
  - On the last byte, go to IDLE; done is NOT pulsed.
- Latency: one cycle from byte_valid to mem_we. Back-to-back byte_valid strobes on consecutive cycles are supported at full rate.
- Address never wraps: the range check guarantees wr_addr ≤ DEPTH-1 for every write.
- Timeout:
  - The counter clears on every byte_valid and on entry to IDLE.
  - It increments each cycle while in GET_LEN, DATA or SKIP.
  - When the counter reaches TIMEOUT-1 with no byte_valid: go to IDLE; set err, err_code=10; no done.
- abort=1 in any state: go to IDLE next cycle; no mem_we that cycle.
  - If the state was not IDLE: set err, err_code=11.
  - Abort in IDLE is a no-op.
  - abort has priority over a coincident byte_valid; that byte is dropped.
- clear_err: clears err and err_code to 0.
  - If a new error event occurs in the same cycle, the new error wins (err=1, new code).
- A later error overwrites err_code. err stays 1 until clear_err or reset.
- rst_n asserted mid-frame: the partial frame is discarded and memory contents already written are untouched (the memory has its own reset). After release the FSM is in IDLE and expects an address byte.
- byte_valid is ignored in no state; every strobe advances the parser.

Test Plan:
- Bytes 0x00, 0x03, 0xAA, 0xBB, 0xCC on consecutive cycles -> mem_we pulses at addr 0, 1, 2 with data AA, BB, CC; done=1 with the third write; busy=0 afterwards; err=0.
- Frame 0xA2, 0x02, 0x11, 0x22 (addresses 162–163, the top boundary) -> writes 0xA2=0x11 and 0xA3=0x22; done pulses; no error.
- Frame 0xA3, 0x02, 0x55, 0x66 (163+2 > 164) -> no mem_we; err=1, err_code=01; no done; the next frame 0x05, 0x01, 0x77 writes addr 5 = 0x77 and pulses done.
- Frame 0x10, 0x04, 0x01, then silence for TIMEOUT cycles -> one write at 0x10; err_code=10; FSM in IDLE; the following frame 0x20, 0x01, 0x99 writes addr 0x20.
- abort asserted together with the second data byte of a 0x00, 0x05 frame -> only addr 0 is written; err_code=11; busy=0 next cycle; clear_err then drops err to 0.
- Frame 0x30, 0x00 -> done pulses with no mem_we; rst_n pulsed low mid-frame -> all outputs read 0 immediately and the next byte is treated as an address.
